// File: rtl/msrv32_wb_load_unit_pkg.sv
// Shared codes for the msrv32 writeback/load stage: writeback source selects,
// load size encodings and the stage state enum.
package msrv32_wb_pkg;

  localparam logic [2:0] WB_ALU  = 3'd0;
  localparam logic [2:0] WB_LOAD = 3'd1;
  localparam logic [2:0] WB_IMM  = 3'd2;
  localparam logic [2:0] WB_PC4  = 3'd3;
  localparam logic [2:0] WB_CSR  = 3'd4;

  localparam logic [1:0] LD_BYTE = 2'b00;
  localparam logic [1:0] LD_HALF = 2'b01;
  localparam logic [1:0] LD_WORD = 2'b10;
  localparam logic [1:0] LD_RSVD = 2'b11;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MEM_WAIT = 1'b1
  } wb_state_t;

endpackage

// File: rtl/msrv32_wb_load_unit_if.sv
// Bundle of execute-side, data-memory and register-file signals of the
// writeback stage; master is the environment, slave is the stage itself.
interface msrv32_wb_load_unit_if;
  import msrv32_wb_pkg::*;

  // Handshake: an instruction transfers on a cycle where ex_valid_in and
  // ex_ready_out are both high; ex_ready_out never depends on ex_valid_in.
  logic        ex_valid_in;
  logic        ex_ready_out;
  logic        flush_in;
  logic [4:0]  rd_addr_in;
  logic        rf_wr_en_in;
  logic [2:0]  wb_sel_in;
  logic [31:0] alu_result_in;
  logic [31:0] imm_in;
  logic [31:0] pc_plus_4_in;
  logic [31:0] csr_data_in;
  logic [1:0]  load_size_in;
  logic        load_unsigned_in;
  logic [31:0] dm_data_in;
  logic        dm_hready_in;
  logic [4:0]  rd_addr_out;
  logic        wr_en_out;
  logic [31:0] rd_out;
  logic        misaligned_load_out;
  logic        bus_err_out;
  wb_state_t   state_dbg_out;

  modport master (
    output ex_valid_in, flush_in, rd_addr_in, rf_wr_en_in, wb_sel_in,
           alu_result_in, imm_in, pc_plus_4_in, csr_data_in, load_size_in,
           load_unsigned_in, dm_data_in, dm_hready_in,
    input  ex_ready_out, rd_addr_out, wr_en_out, rd_out,
           misaligned_load_out, bus_err_out, state_dbg_out
  );

  modport slave (
    input  ex_valid_in, flush_in, rd_addr_in, rf_wr_en_in, wb_sel_in,
           alu_result_in, imm_in, pc_plus_4_in, csr_data_in, load_size_in,
           load_unsigned_in, dm_data_in, dm_hready_in,
    output ex_ready_out, rd_addr_out, wr_en_out, rd_out,
           misaligned_load_out, bus_err_out, state_dbg_out
  );

endinterface

// File: rtl/msrv32_load_align.sv
// Combinational lane select and sign/zero extension of a data-memory read word.
module msrv32_load_align
  import msrv32_wb_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic [1:0]  i_addr,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_value
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_data[7:0];
    case (i_addr)
      2'd0: w_byte = i_data[7:0];
      2'd1: w_byte = i_data[15:8];
      2'd2: w_byte = i_data[23:16];
      2'd3: w_byte = i_data[31:24];
      default: w_byte = i_data[7:0];
    endcase
  end

  assign w_half = i_addr[1] ? i_data[31:16] : i_data[15:0];

  always_comb begin
    o_value = i_data;
    case (i_size)
      LD_BYTE: o_value = i_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      LD_HALF: o_value = i_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: o_value = i_data;
    endcase
  end

endmodule

// File: rtl/msrv32_wb_load_unit.sv
// msrv32 writeback stage: selects the writeback source, waits on data memory
// for loads, and drives a registered write port into the integer register file.
module msrv32_wb_load_unit
  import msrv32_wb_pkg::*;
#(
  parameter int MAX_WAIT   = 16,
  parameter int WAIT_CNT_W = 8
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  msrv32_wb_load_unit_if.slave  wb
);

  localparam logic [WAIT_CNT_W-1:0] LP_LAST_WAIT = WAIT_CNT_W'(MAX_WAIT - 1);

  wb_state_t             r_state;
  logic [WAIT_CNT_W-1:0] r_wait_cnt;
  logic [4:0]            r_rd_cap;
  logic                  r_we_cap;
  logic [1:0]            r_size_cap;
  logic                  r_uns_cap;
  logic [1:0]            r_off_cap;
  logic [4:0]            r_rd_addr;
  logic [31:0]           r_rd_data;
  logic                  r_wr_en;
  logic                  r_misaligned;
  logic                  r_bus_err;

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_is_load;
  logic                  w_misaligned;
  logic                  w_direct_we;
  logic [31:0]           w_sel_data;
  logic [31:0]           w_aligned;
  logic                  w_timeout;

  assign w_ready     = (r_state == ST_IDLE) && !wb.flush_in;
  assign w_accept    = wb.ex_valid_in && w_ready;
  assign w_is_load   = (wb.wb_sel_in == WB_LOAD);
  assign w_direct_we = wb.rf_wr_en_in && (wb.rd_addr_in != 5'd0);
  assign w_timeout   = !wb.dm_hready_in && (r_wait_cnt == LP_LAST_WAIT);

  always_comb begin
    w_misaligned = 1'b0;
    case (wb.load_size_in)
      LD_BYTE: w_misaligned = 1'b0;
      LD_HALF: w_misaligned = wb.alu_result_in[0];
      default: w_misaligned = (wb.alu_result_in[1:0] != 2'b00);
    endcase
  end

  // Reserved selects deliberately write zero rather than stale data.
  always_comb begin
    w_sel_data = 32'd0;
    case (wb.wb_sel_in)
      WB_ALU:  w_sel_data = wb.alu_result_in;
      WB_IMM:  w_sel_data = wb.imm_in;
      WB_PC4:  w_sel_data = wb.pc_plus_4_in;
      WB_CSR:  w_sel_data = wb.csr_data_in;
      default: w_sel_data = 32'd0;
    endcase
  end

  msrv32_load_align u_align (
    .i_data     (wb.dm_data_in),
    .i_addr     (r_off_cap),
    .i_size     (r_size_cap),
    .i_unsigned (r_uns_cap),
    .o_value    (w_aligned)
  );

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_state      <= ST_IDLE;
      r_wait_cnt   <= '0;
      r_rd_cap     <= 5'd0;
      r_we_cap     <= 1'b0;
      r_size_cap   <= 2'b00;
      r_uns_cap    <= 1'b0;
      r_off_cap    <= 2'b00;
      r_rd_addr    <= 5'd0;
      r_rd_data    <= 32'd0;
      r_wr_en      <= 1'b0;
      r_misaligned <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      r_wr_en      <= 1'b0;
      r_misaligned <= 1'b0;
      r_bus_err    <= 1'b0;
      if (wb.flush_in) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_accept) begin
              if (!w_is_load) begin
                r_wr_en <= w_direct_we;
                if (w_direct_we) begin
                  r_rd_addr <= wb.rd_addr_in;
                  r_rd_data <= w_sel_data;
                end
              end else if (w_misaligned) begin
                r_misaligned <= 1'b1;
              end else begin
                r_rd_cap   <= wb.rd_addr_in;
                r_we_cap   <= wb.rf_wr_en_in;
                r_size_cap <= wb.load_size_in;
                r_uns_cap  <= wb.load_unsigned_in;
                r_off_cap  <= wb.alu_result_in[1:0];
                r_wait_cnt <= '0;
                r_state    <= ST_MEM_WAIT;
              end
            end
          end
          ST_MEM_WAIT: begin
            // hready on the final allowed wait cycle still wins over timeout.
            if (wb.dm_hready_in) begin
              if (r_we_cap && (r_rd_cap != 5'd0)) begin
                r_wr_en   <= 1'b1;
                r_rd_addr <= r_rd_cap;
                r_rd_data <= w_aligned;
              end
              r_state <= ST_IDLE;
            end else if (w_timeout) begin
              r_bus_err <= 1'b1;
              r_state   <= ST_IDLE;
            end else begin
              r_wait_cnt <= r_wait_cnt + 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign wb.ex_ready_out        = w_ready;
  assign wb.rd_addr_out         = r_rd_addr;
  assign wb.rd_out              = r_rd_data;
  assign wb.wr_en_out           = r_wr_en;
  assign wb.misaligned_load_out = r_misaligned;
  assign wb.bus_err_out         = r_bus_err;
  assign wb.state_dbg_out       = r_state;

endmodule

// File: tb/tb_msrv32_wb_load_unit.sv
// Self-checking bench for msrv32_wb_load_unit: table of single transactions
// plus hand-written flush, back-to-back and reset sequences.
module tb_msrv32_wb_load_unit;
  import msrv32_wb_pkg::*;

  localparam int MAX_WAIT = 4;
  localparam int K_NONE = 0, K_WR = 1, K_MIS = 2, K_BERR = 3;

  typedef struct {
    logic [2:0]  sel;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] a;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic [31:0] csr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] dm;
    int          dly;
    int          kind;
    logic [31:0] e_rd;
  } vec_t;

  logic clk_in;
  logic reset_in;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [39:0] exp_q[$];
  logic [4:0]  last_addr = 5'd0;
  logic [31:0] last_rd   = 32'd0;
  vec_t        vecs[19];

  msrv32_wb_load_unit_if wb();

  msrv32_wb_load_unit #(.MAX_WAIT(MAX_WAIT), .WAIT_CNT_W(8)) dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .wb       (wb)
  );

  // clock / reset
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic logic [39:0] pack(input logic we, input logic mis, input logic berr,
                                       input logic [4:0] addr, input logic [31:0] data);
    return {we, mis, berr, addr, data};
  endfunction

  function automatic vec_t mk(input logic [2:0] sel, input logic [4:0] rd, input logic we,
                              input logic [31:0] a, input logic [31:0] imm, input logic [31:0] pc4,
                              input logic [31:0] csr, input logic [1:0] size, input logic uns,
                              input logic [31:0] dm, input int dly, input int kind,
                              input logic [31:0] e_rd);
    vec_t v;
    v.sel = sel; v.rd = rd; v.we = we; v.a = a; v.imm = imm; v.pc4 = pc4; v.csr = csr;
    v.size = size; v.uns = uns; v.dm = dm; v.dly = dly; v.kind = kind; v.e_rd = e_rd;
    return v;
  endfunction

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int kind, input logic [4:0] rd, input logic [31:0] data);
    case (kind)
      K_WR: begin
        exp_q.push_back(pack(1'b1, 1'b0, 1'b0, rd, data));
        last_addr = rd;
        last_rd   = data;
      end
      K_MIS:  exp_q.push_back(pack(1'b0, 1'b1, 1'b0, last_addr, last_rd));
      K_BERR: exp_q.push_back(pack(1'b0, 1'b0, 1'b1, last_addr, last_rd));
      default: ;
    endcase
  endtask

  task automatic idle_inputs();
    wb.ex_valid_in = 1'b0; wb.flush_in = 1'b0; wb.rd_addr_in = 5'd0; wb.rf_wr_en_in = 1'b0;
    wb.wb_sel_in = 3'd0; wb.alu_result_in = 32'd0; wb.imm_in = 32'd0; wb.pc_plus_4_in = 32'd0;
    wb.csr_data_in = 32'd0; wb.load_size_in = 2'b00; wb.load_unsigned_in = 1'b0;
    wb.dm_data_in = 32'd0; wb.dm_hready_in = 1'b0;
  endtask

  task automatic drive_vec(input vec_t v);
    wb.wb_sel_in = v.sel; wb.rd_addr_in = v.rd; wb.rf_wr_en_in = v.we;
    wb.alu_result_in = v.a; wb.imm_in = v.imm; wb.pc_plus_4_in = v.pc4;
    wb.csr_data_in = v.csr; wb.load_size_in = v.size; wb.load_unsigned_in = v.uns;
    wb.ex_valid_in = 1'b1;
  endtask

  // driver: one transaction from accept to its result pulse
  task automatic run_vec(input vec_t v, input string name);
    int n;
    @(negedge clk_in);
    drive_vec(v);
    push_exp(v.kind, v.rd, v.e_rd);
    @(negedge clk_in);
    wb.ex_valid_in = 1'b0;
    if (v.sel == WB_LOAD && v.kind != K_MIS) begin
      n = (v.dly < MAX_WAIT) ? v.dly + 1 : MAX_WAIT;
      for (int c = 0; c < n; c++) begin
        check({name, "_ready_low"}, 40'(wb.ex_ready_out), 40'd0);
        wb.dm_hready_in = (c == v.dly);
        wb.dm_data_in   = v.dm;
        @(negedge clk_in);
      end
      wb.dm_hready_in = 1'b0;
    end
    #2;
    check({name, "_drain"}, 40'(exp_q.size()), 40'd0);
    check({name, "_ready_back"}, 40'(wb.ex_ready_out), 40'd1);
  endtask

  // scoreboard: every result pulse must match the oldest expectation
  always @(negedge clk_in) begin
    logic [39:0] act;
    if (!reset_in && (wb.wr_en_out || wb.misaligned_load_out || wb.bus_err_out)) begin
      act = pack(wb.wr_en_out, wb.misaligned_load_out, wb.bus_err_out, wb.rd_addr_out, wb.rd_out);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got %h expected none", act);
      end else begin
        check("sb_out", act, exp_q.pop_front());
      end
    end
  end

  initial begin
    //            sel      rd     we   a             imm           pc4           csr           size     uns   dm            dly kind    e_rd
    vecs[0]  = mk(WB_ALU,  5'd5,  1, 32'h1234_5678, 32'h0,        32'h0,        32'h0,        LD_WORD, 0, 32'h0,        0, K_WR,   32'h1234_5678);
    vecs[1]  = mk(WB_ALU,  5'd0,  1, 32'h1234_5678, 32'h0,        32'h0,        32'h0,        LD_WORD, 0, 32'h0,        0, K_NONE, 32'h0);
    vecs[2]  = mk(WB_IMM,  5'd7,  1, 32'h1111_1111, 32'hABCD_E000, 32'h0,       32'h0,        LD_WORD, 0, 32'h0,        0, K_WR,   32'hABCD_E000);
    vecs[3]  = mk(WB_PC4,  5'd1,  1, 32'h1111_1111, 32'h0,        32'h0000_0104, 32'h0,       LD_WORD, 0, 32'h0,        0, K_WR,   32'h0000_0104);
    vecs[4]  = mk(WB_CSR,  5'd31, 1, 32'h1111_1111, 32'h0,        32'h0,        32'hDEAD_BEEF, LD_WORD, 0, 32'h0,       0, K_WR,   32'hDEAD_BEEF);
    vecs[5]  = mk(3'd5,    5'd9,  1, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, LD_WORD, 0, 32'h0,     0, K_WR,   32'h0);
    vecs[6]  = mk(WB_ALU,  5'd3,  0, 32'h7777_7777, 32'h0,        32'h0,        32'h0,        LD_WORD, 0, 32'h0,        0, K_NONE, 32'h0);
    vecs[7]  = mk(WB_LOAD, 5'd10, 1, 32'h0000_0103, 32'h0,        32'h0,        32'h0,        LD_BYTE, 0, 32'h80AA_BBCC, 2, K_WR,  32'hFFFF_FF80);
    vecs[8]  = mk(WB_LOAD, 5'd11, 1, 32'h0000_0102, 32'h0,        32'h0,        32'h0,        LD_HALF, 1, 32'h8001_0000, 0, K_WR,  32'h0000_8001);
    vecs[9]  = mk(WB_LOAD, 5'd12, 1, 32'h0000_0101, 32'h0,        32'h0,        32'h0,        LD_WORD, 0, 32'h0,        0, K_MIS,  32'h0);
    vecs[10] = mk(WB_LOAD, 5'd12, 1, 32'h0000_0103, 32'h0,        32'h0,        32'h0,        LD_HALF, 0, 32'h0,        0, K_MIS,  32'h0);
    vecs[11] = mk(WB_LOAD, 5'd12, 1, 32'h0000_0101, 32'h0,        32'h0,        32'h0,        LD_BYTE, 1, 32'h1234_5678, 1, K_WR,  32'h0000_0056);
    vecs[12] = mk(WB_LOAD, 5'd13, 1, 32'h0000_0100, 32'h0,        32'h0,        32'h0,        LD_HALF, 0, 32'h1234_F00F, 0, K_WR,  32'hFFFF_F00F);
    vecs[13] = mk(WB_LOAD, 5'd14, 1, 32'h0000_0200, 32'h0,        32'h0,        32'h0,        LD_WORD, 0, 32'hCAFE_F00D, 3, K_WR,  32'hCAFE_F00D);
    vecs[14] = mk(WB_LOAD, 5'd15, 1, 32'h0000_0204, 32'h0,        32'h0,        32'h0,        LD_RSVD, 0, 32'h0102_0304, 0, K_WR,  32'h0102_0304);
    vecs[15] = mk(WB_LOAD, 5'd16, 1, 32'h0000_0102, 32'h0,        32'h0,        32'h0,        LD_BYTE, 0, 32'h007F_0000, 1, K_WR,  32'h0000_007F);
    vecs[16] = mk(WB_LOAD, 5'd0,  1, 32'h0000_0000, 32'h0,        32'h0,        32'h0,        LD_WORD, 0, 32'h5555_5555, 0, K_NONE, 32'h0);
    vecs[17] = mk(WB_LOAD, 5'd17, 1, 32'h0000_0300, 32'h0,        32'h0,        32'h0,        LD_WORD, 0, 32'h9999_9999, 4, K_BERR, 32'h0);
    vecs[18] = mk(WB_LOAD, 5'd18, 1, 32'h0000_0302, 32'h0,        32'h0,        32'h0,        LD_RSVD, 0, 32'h0,        0, K_MIS,  32'h0);

    idle_inputs();
    reset_in = 1'b1;
    repeat (2) @(negedge clk_in);
    check("rst_ready",  40'(wb.ex_ready_out), 40'd1);
    check("rst_outs",   pack(wb.wr_en_out, wb.misaligned_load_out, wb.bus_err_out,
                             wb.rd_addr_out, wb.rd_out), 40'd0);
    check("rst_state",  40'(wb.state_dbg_out), 40'(ST_IDLE));
    reset_in = 1'b0;

    for (int i = 0; i < 19; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // flush while waiting on memory: no write even if hready follows
    @(negedge clk_in);
    drive_vec(mk(WB_LOAD, 5'd20, 1, 32'h400, 0, 0, 0, LD_WORD, 0, 0, 0, K_NONE, 0));
    @(negedge clk_in);
    wb.ex_valid_in = 1'b0;
    check("flush_wait_state", 40'(wb.state_dbg_out), 40'(ST_MEM_WAIT));
    wb.flush_in = 1'b1;
    #1 check("flush_ready_low", 40'(wb.ex_ready_out), 40'd0);
    @(negedge clk_in);
    wb.flush_in = 1'b0; wb.dm_hready_in = 1'b1; wb.dm_data_in = 32'hAAAA_5555;
    check("flush_to_idle", 40'(wb.state_dbg_out), 40'(ST_IDLE));
    @(negedge clk_in);
    wb.dm_hready_in = 1'b0;
    check("flush_no_write", 40'(wb.wr_en_out), 40'd0);

    // flush suppresses a presented instruction
    @(negedge clk_in);
    drive_vec(mk(WB_ALU, 5'd4, 1, 32'h4444, 0, 0, 0, LD_WORD, 0, 0, 0, K_NONE, 0));
    wb.flush_in = 1'b1;
    #1 check("flush_blocks_ready", 40'(wb.ex_ready_out), 40'd0);
    @(negedge clk_in);
    wb.ex_valid_in = 1'b0; wb.flush_in = 1'b0;
    check("flush_blocks_write", 40'(wb.wr_en_out), 40'd0);

    // write already registered completes under a flush
    @(negedge clk_in);
    drive_vec(mk(WB_ALU, 5'd6, 1, 32'h0000_0066, 0, 0, 0, LD_WORD, 0, 0, 0, K_NONE, 0));
    push_exp(K_WR, 5'd6, 32'h0000_0066);
    @(negedge clk_in);
    wb.ex_valid_in = 1'b0; wb.flush_in = 1'b1;
    #2 check("flush_keeps_write", 40'(exp_q.size()), 40'd0);
    @(negedge clk_in);
    wb.flush_in = 1'b0;

    // back-to-back non-load accepts, one per cycle
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      drive_vec(mk(WB_ALU, 5'(k + 1), 1, 32'hB0B0_0000 + 32'(k), 0, 0, 0, LD_WORD, 0, 0, 0, K_NONE, 0));
      push_exp(K_WR, 5'(k + 1), 32'hB0B0_0000 + 32'(k));
      #1 check("b2b_ready", 40'(wb.ex_ready_out), 40'd1);
    end
    @(negedge clk_in);
    wb.ex_valid_in = 1'b0;
    #2 check("b2b_drain", 40'(exp_q.size()), 40'd0);

    // reset in the middle of a memory wait
    @(negedge clk_in);
    drive_vec(mk(WB_LOAD, 5'd21, 1, 32'h500, 0, 0, 0, LD_WORD, 0, 0, 0, K_NONE, 0));
    @(negedge clk_in);
    wb.ex_valid_in = 1'b0;
    check("rst_mid_wait_state", 40'(wb.state_dbg_out), 40'(ST_MEM_WAIT));
    #1 reset_in = 1'b1;
    #1;
    check("rst_async_outs", pack(wb.wr_en_out, wb.misaligned_load_out, wb.bus_err_out,
                                 wb.rd_addr_out, wb.rd_out), 40'd0);
    check("rst_async_state", 40'(wb.state_dbg_out), 40'(ST_IDLE));
    check("rst_async_ready", 40'(wb.ex_ready_out), 40'd1);
    last_addr = 5'd0; last_rd = 32'd0;
    @(negedge clk_in);
    reset_in = 1'b0; wb.dm_hready_in = 1'b1; wb.dm_data_in = 32'h1357_9BDF;
    @(negedge clk_in);
    wb.dm_hready_in = 1'b0;
    check("rst_no_write", 40'(wb.wr_en_out), 40'd0);

    run_vec(mk(WB_ALU, 5'd8, 1, 32'h0BAD_CAFE, 0, 0, 0, LD_WORD, 0, 0, 0, K_WR, 32'h0BAD_CAFE),
            "post_rst");

    repeat (2) @(negedge clk_in);
    #2 check("final_queue_empty", 40'(exp_q.size()), 40'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/msrv32_wb_load_unit.md
Name: msrv32_wb_load_unit

Overview:
- Writeback stage of the msrv32 core, sitting between execute and the integer register file.
- Accepts one completed instruction per handshake from execute and selects the writeback source.
- For loads, waits on the data-memory ready signal, then aligns and sign- or zero-extends the returned word.
- Drives a registered write port (rd_addr_out, wr_en_out, rd_out) straight into the integer register file, and reports misaligned loads and memory timeouts.

Parameters:
- MAX_WAIT, 16: maximum cycles spent in MEM_WAIT before a bus timeout. Range 1..255.
- WAIT_CNT_W, 8: width of the wait counter. Must satisfy 2^WAIT_CNT_W > MAX_WAIT.

Ports:
- clk_in  input  1  core clock
- reset_in  input  1  asynchronous, active-high reset
- ex_valid_in  input  1  execute presents a completed instruction
- ex_ready_out  output  1  this stage can accept an instruction
- flush_in  input  1  synchronous abort of in-flight and presented work
- rd_addr_in  input  5  destination register
- rf_wr_en_in  input  1  instruction writes rd
- wb_sel_in  input  3  source select: 0 ALU, 1 LOAD, 2 IMM (LUI), 3 PC+4, 4 CSR; 5-7 reserved
- alu_result_in  input  32  ALU result; also the load effective address
- imm_in  input  32  U-immediate
- pc_plus_4_in  input  32  link value
- csr_data_in  input  32  CSR read data
- load_size_in  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- load_unsigned_in  input  1  zero-extend instead of sign-extend
- dm_data_in  input  32  data-memory read word
- dm_hready_in  input  1  read data valid this cycle
- rd_addr_out  output  5  to register file
- wr_en_out  output  1  to register file; one-cycle pulse
- rd_out  output  32  to register file
- misaligned_load_out  output  1  one-cycle pulse
- bus_err_out  output  1  one-cycle pulse on memory timeout

Behaviour:
- Reset:
  - Clock is clk_in; reset_in is asynchronous and active-high.
  - On reset: state IDLE; all outputs 0 except ex_ready_out = 1; wait counter 0.
- Handshake:
  - ex_ready_out = (state == IDLE) and not flush_in.
  - Accept occurs when ex_valid_in and ex_ready_out are both high.
- States:
  - IDLE, MEM_WAIT. Encoding is a 1-bit enum in the package.
- Non-load accept (wb_sel != LOAD):
  - Next cycle: wr_en_out = rf_wr_en_in and (rd_addr_in != 0); rd_addr_out and rd_out take the selected source.
  - State stays IDLE, so throughput is 1 per cycle.
  - Reserved wb_sel values write 0.
- Misalignment check at load accept:
  - Misaligned means half with addr[0] = 1, or word/reserved with addr[1:0] != 0.
  - Misaligned load: next cycle misaligned_load_out = 1 and wr_en_out = 0; state stays IDLE.
- Aligned load accept:
  - Capture rd, wr-enable, size, unsigned flag and addr[1:0]; go to MEM_WAIT; clear the wait counter.
  - wr_en_out = 0 in the following cycle.
- MEM_WAIT:
  - If dm_hready_in is high: next cycle wr_en_out = captured enable and (rd != 0), rd_out = aligned data; go to IDLE.
  - Otherwise increment the counter. When the counter reaches MAX_WAIT with hready still low: next cycle bus_err_out = 1, no write, go to IDLE.
  - hready arriving in the same cycle as the counter reaching MAX_WAIT counts as success.
- Alignment:
  - byte = dm_data_in[8*addr[1:0] +: 8].
  - half = addr[1] ? [31:16] : [15:0].
  - Extend to 32 bits per load_unsigned.
- Pulses: wr_en_out, misaligned_load_out and bus_err_out each last exactly one cycle and are mutually exclusive.
- Flush:
  - flush_in forces the state to IDLE and suppresses the accept in that cycle.
  - The next cycle carries no write and no error pulse.
  - A write already registered for this cycle still completes.
- Reset mid-MEM_WAIT: returns to IDLE immediately; no write is emitted.
- Output stability: rd_addr_out and rd_out hold their last values when wr_en_out = 0.

Decomposition:
- Package msrv32_wb_pkg:
  - wb_sel codes (WB_ALU, WB_LOAD, WB_IMM, WB_PC4, WB_CSR)
  - load size codes
  - state enum
- Sub-module msrv32_load_align: purely combinational. Inputs are data, addr[1:0], size and unsigned; output is the 32-bit extended value.

Test Plan:
- ALU writeback: accept wb_sel=0, rd=5, alu=0x1234_5678 -> next cycle wr_en_out=1, rd_addr_out=5, rd_out=0x1234_5678. Repeat with rd=0 -> wr_en_out=0.
- Load byte signed: addr=0x103, dm_data=0x80AA_BBCC, hready after 2 wait cycles -> wr_en_out=1, rd_out=0xFFFF_FF80; ex_ready_out low through MEM_WAIT.
- Load half unsigned: addr=0x102, dm_data=0x8001_0000, hready immediate -> rd_out=0x0000_8001, one cycle after hready.
- Misaligned LW: addr=0x101 -> misaligned_load_out pulses once, wr_en_out=0, ex_ready_out stays 1.
- Timeout: MAX_WAIT=4, hready held low -> bus_err_out pulses once, then IDLE with no write. Variant with hready high on the 4th wait cycle -> normal write.
- Flush and reset: flush_in in MEM_WAIT -> IDLE, no write even if hready arrives the next cycle. reset_in asserted mid-MEM_WAIT -> outputs 0 asynchronously.
